display_status_encoder: RTL

- Sequential front end for the coffee-machine 7-segment path.
- Takes the selected coffee type and the process-step events from the machine controller and produces time-multiplexed 4-bit `char_sel` codes plus digit enables.
- Digit 0 shows the coffee type; digit 1 shows the process step; the FIN step blinks, then the block returns to idle on its own.
- `char_sel` feeds the existing 7-segment decoder directly. Code 15 is the blank code (decoder turns all segments off).

---
 rtl/display_status_encoder_if.sv | 30 +++
 rtl/display_status_encoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/display_status_encoder_if.sv
// Display status encoder bus.
// The controller (master) drives the type/step strobes and the clear request.
// The encoder (slave) drives the 7-segment character code, the digit enables
// and the status flags.
interface display_status_encoder_if;

  // Requests from the machine controller
  logic       clear;
  logic       type_valid;
  logic [1:0] type_sel;
  logic       state_valid;
  logic [2:0] state_code;

  // Display side and status
  logic [3:0] char_sel;
  logic [1:0] digit_en;
  logic       busy;
  logic       fin_done;

  modport master (
    output clear, type_valid, type_sel, state_valid, state_code,
    input  char_sel, digit_en, busy, fin_done
  );

  modport slave (
    input  clear, type_valid, type_sel, state_valid, state_code,
    output char_sel, digit_en, busy, fin_done
  );

endinterface

// File: rtl/display_status_encoder.sv
// Display status encoder for the coffee-machine 7-segment path.
// Digit 0 shows the selected coffee type and digit 1 shows the current
// process step. The two digits are time-multiplexed by a free-running
// refresh counter. The FIN step blinks for FIN_BLINKS periods, then the
// block returns to idle by itself and pulses fin_done.
module display_status_encoder #(
  parameter int REFRESH_DIV = 50000,    // clock cycles per digit slot, >= 2
  parameter int BLINK_DIV   = 25000000, // clock cycles per blink half-period, >= 2
  parameter int FIN_BLINKS  = 4         // full on/off periods in FIN, >= 1
) (
  input  logic                    clk,
  input  logic                    rst,
  display_status_encoder_if.slave bus
);

  localparam int REFRESH_W = $clog2(REFRESH_DIV);
  localparam int BLINK_W   = $clog2(BLINK_DIV);
  // The period counter only has to hold 0..FIN_BLINKS-1
  localparam int PERIOD_W  = (FIN_BLINKS > 1) ? $clog2(FIN_BLINKS) : 1;

  localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_DIV - 1);
  localparam logic [PERIOD_W-1:0]  PERIOD_LAST  = PERIOD_W'(FIN_BLINKS - 1);

  // Character codes understood by the downstream 7-segment decoder
  localparam logic [3:0] CHAR_BLANK = 4'd15;
  localparam logic [3:0] CHAR_FIN   = 4'd8;

  // Controller step codes that carry a special meaning
  localparam logic [2:0] CODE_IDLE    = 3'd0;
  localparam logic [2:0] CODE_FIN     = 3'd6;
  localparam logic [1:0] TYPE_INVALID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           type_q, type_d;
  logic [3:0]           step_q, step_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_on_q, blink_on_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic [REFRESH_W-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]           digit_en_q, digit_en_d;
  logic [3:0]           char_sel_q, char_sel_d;
  logic                 busy_q, busy_d;
  logic                 fin_done_q, fin_done_d;

  logic       refresh_tc;
  logic       blink_tc;
  logic       type_ok;
  logic       step_ok;
  logic       fin_req;
  logic       idle_req;
  logic       go_idle;
  logic [3:0] type_char;
  logic [3:0] step_char;

  // Decode the incoming strobes once so the FSM reads as plain intent
  assign refresh_tc = (refresh_cnt_q == REFRESH_LAST);
  assign blink_tc   = (blink_cnt_q == BLINK_LAST);
  assign type_ok    = bus.type_valid && (bus.type_sel != TYPE_INVALID);
  assign step_ok    = bus.state_valid && (bus.state_code >= 3'd1)
                      && (bus.state_code <= 3'd5);
  assign fin_req    = bus.state_valid && (bus.state_code == CODE_FIN);
  assign idle_req   = bus.state_valid && (bus.state_code == CODE_IDLE);

  // espresso/leche/capuchino map straight to 0/1/2
  assign type_char  = {2'b00, bus.type_sel};
  // agua..crema (1..5) map to 3..7
  assign step_char  = {1'b0, bus.state_code} + 4'd2;

  // Refresh scan: the slot counter and digit enable free-run in every state
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 1'b1;
    digit_en_d    = digit_en_q;
    if (refresh_tc) begin
      refresh_cnt_d = '0;
      digit_en_d    = {digit_en_q[0], digit_en_q[1]};
    end
  end

  // Next-state, register updates and FIN blink sequencing
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    type_d      = type_q;
    step_d      = step_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    period_d    = period_q;
    fin_done_d  = 1'b0;
    go_idle     = 1'b0;

    if (bus.clear) begin
      go_idle = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (type_ok) type_d = type_char;
          if (step_ok) begin
            step_d  = step_char;
            state_d = ST_SHOW;
          end
        end

        ST_SHOW: begin
          if (type_ok) type_d = type_char;
          if (step_ok) begin
            step_d = step_char;
          end else if (fin_req) begin
            state_d     = ST_FIN;
            step_d      = CHAR_FIN;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
            period_d    = '0;
          end else if (idle_req) begin
            go_idle = 1'b1;
          end
        end

        ST_FIN: begin
          if (idle_req) begin
            go_idle = 1'b1;
          end else if (blink_tc) begin
            blink_cnt_d = '0;
            if (blink_on_q) begin
              blink_on_d = 1'b0;
            end else if (period_q == PERIOD_LAST) begin
              // Last off phase ends: leave instead of lighting up again
              go_idle    = 1'b1;
              fin_done_d = 1'b1;
            end else begin
              blink_on_d = 1'b1;
              period_d   = period_q + 1'b1;
            end
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end

        default: go_idle = 1'b1;
      endcase
    end

    // Every route back to IDLE forgets the latched type and step
    if (go_idle) begin
      state_d     = ST_IDLE;
      type_d      = CHAR_BLANK;
      step_d      = CHAR_BLANK;
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
      period_d    = '0;
    end
  end

  // Character for the digit that becomes active on the coming edge
  always_comb begin
    char_sel_d = CHAR_BLANK;
    unique case (state_q)
      ST_SHOW: char_sel_d = digit_en_d[1] ? step_q : type_q;
      ST_FIN:  char_sel_d = digit_en_d[1] ? (blink_on_q ? CHAR_FIN : CHAR_BLANK)
                                          : type_q;
      default: char_sel_d = CHAR_BLANK;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      type_q        <= CHAR_BLANK;
      step_q        <= CHAR_BLANK;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      period_q      <= '0;
      refresh_cnt_q <= '0;
      digit_en_q    <= 2'b01;
      char_sel_q    <= CHAR_BLANK;
      busy_q        <= 1'b0;
      fin_done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      type_q        <= type_d;
      step_q        <= step_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      period_q      <= period_d;
      refresh_cnt_q <= refresh_cnt_d;
      digit_en_q    <= digit_en_d;
      char_sel_q    <= char_sel_d;
      busy_q        <= busy_d;
      fin_done_q    <= fin_done_d;
    end
  end

  assign bus.char_sel = char_sel_q;
  assign bus.digit_en = digit_en_q;
  assign bus.busy     = busy_q;
  assign bus.fin_done = fin_done_q;

endmodule
